// File: rtl/mole_draw_arbiter_if.sv
// Pixel-write bus from the mole draw arbiter to the vga_adapter, plus its status strobes.
interface mole_draw_arbiter_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (output x, y, colour, plot, busy, done);
  modport slave  (input  x, y, colour, plot, busy, done);
endinterface

// File: rtl/mole_draw_arbiter.sv
// Round-robin arbiter that rasterises one mole block at a time onto the shared vga pixel port.
// Each lane remembers what its block shows on screen and flags a mismatch against its target.
module mole_draw_lane (
  input  logic clock,
  input  logic resetn,
  input  logic target,
  input  logic commit,
  input  logic val,
  output logic drawn,
  output logic pending
);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     drawn <= 1'b0;
    else if (commit) drawn <= val;
  end

  assign pending = target ^ drawn;
endmodule

module mole_draw_arbiter #(
  parameter int          NUM_MOLES  = 3,
  parameter int          BLOCK_W    = 8,
  parameter int          BLOCK_H    = 8,
  parameter int          X_BASE     = 1,
  parameter int          X_STEP     = 8,
  parameter int          Y_TOP      = 33,
  parameter logic [2:0]  ON_COLOUR  = 3'b100,
  parameter logic [2:0]  OFF_COLOUR = 3'b000
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 game,
  input  logic [NUM_MOLES-1:0] mole_state,
  mole_draw_arbiter_if.master  vga
);
  localparam int GW  = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
  localparam int CXW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int CYW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, COMMIT} state_t;

  state_t               state, state_d;
  logic [GW-1:0]        grant, grant_d, last_grant, last_d, g_idx;
  logic                 val, val_d, g_found, commit;
  logic [CXW-1:0]       cx, cx_d;
  logic [CYW-1:0]       cy, cy_d;
  logic [7:0]           x_q, x_d;
  logic [6:0]           y_q, y_d;
  logic [2:0]           colour_q, colour_d;
  logic                 plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_MOLES-1:0] target, drawn, pending;

  assign target = {NUM_MOLES{game}} & mole_state;

  for (genvar i = 0; i < NUM_MOLES; i++) begin : g_lane
    mole_draw_lane u_lane (
      .clock   (clock),
      .resetn  (resetn),
      .target  (target[i]),
      .commit  (commit && (grant == GW'(i))),
      .val     (val),
      .drawn   (drawn[i]),
      .pending (pending[i])
    );
  end

  // Search starts one past the last committed block so every requester waits at most NUM_MOLES-1 grants.
  always_comb begin
    logic [GW-1:0] idx;
    g_found = 1'b0;
    g_idx   = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_MOLES; k++) begin
      idx = GW'((int'(last_grant) + k) % NUM_MOLES);
      if (!g_found && pending[idx]) begin
        g_found = 1'b1;
        g_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    val_d    = val;
    last_d   = last_grant;
    cx_d     = cx;
    cy_d     = cy;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (g_found) begin
          state_d  = DRAW;
          grant_d  = g_idx;
          val_d    = target[g_idx];
          colour_d = target[g_idx] ? ON_COLOUR : OFF_COLOUR;
          cx_d     = '0;
          cy_d     = '0;
          plot_d   = 1'b1;
          busy_d   = 1'b1;
        end
      end
      DRAW: begin
        busy_d = 1'b1;
        if (cx == CXW'(BLOCK_W - 1)) begin
          cx_d = '0;
          if (cy == CYW'(BLOCK_H - 1)) begin
            cy_d    = '0;
            state_d = COMMIT;
            done_d  = 1'b1;
          end else begin
            cy_d   = cy + 1'b1;
            plot_d = 1'b1;
          end
        end else begin
          cx_d   = cx + 1'b1;
          plot_d = 1'b1;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        last_d  = grant;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so the coordinates loaded here belong to the pixel of the next cycle.
    x_d = plot_d ? 8'(X_BASE + int'(grant_d) * X_STEP + int'(cx_d)) : x_q;
    y_d = plot_d ? 7'(Y_TOP + int'(cy_d)) : y_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= '0;
      val        <= 1'b0;
      last_grant <= GW'(NUM_MOLES - 1);
      cx         <= '0;
      cy         <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= OFF_COLOUR;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      val        <= val_d;
      last_grant <= last_d;
      cx         <= cx_d;
      cy         <= cy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign vga.x      = x_q;
  assign vga.y      = y_q;
  assign vga.colour = colour_q;
  assign vga.plot   = plot_q;
  assign vga.busy   = busy_q;
  assign vga.done   = done_q;
endmodule

// File: tb/tb_mole_draw_arbiter.sv
// Scoreboard bench: expected pixels are queued as stimulus is applied and popped on each plot.
module tb_mole_draw_arbiter;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       game = 1'b1;
  logic [2:0] mole_state = 3'b111;

  mole_draw_arbiter_if vif ();

  mole_draw_arbiter u_dut (
    .clock      (clock),
    .resetn     (resetn),
    .game       (game),
    .mole_state (mole_state),
    .vga        (vif)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int col;
    int gap;
  } pix_t;

  pix_t sb[$];
  int passes = 0, total = 0;
  int cyc = 0, last_plot = 0, plot_cnt = 0, done_cnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // gap: required non-plot cycles before the first pixel, -1 when the block follows an idle period.
  task automatic push_block(input int b, input int col, input int gap);
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 8; xx++) begin
        pix_t p;
        p.x   = 1 + b * 8 + xx;
        p.y   = 33 + yy;
        p.col = col;
        p.gap = (xx == 0 && yy == 0) ? gap : 0;
        sb.push_back(p);
      end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clock);
    while ((sb.size() != 0 || vif.busy) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk(tag, sb.size(), 0);
    repeat (4) @(negedge clock);
  endtask

  task automatic wait_plots(input int target_cnt, input string tag);
    int n = 0;
    while (plot_cnt < target_cnt && n < 500) begin
      @(posedge clock);
      n++;
    end
    chk(tag, int'(plot_cnt >= target_cnt), 1);
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (resetn) begin
      if (vif.done) done_cnt++;
      if (vif.plot) begin
        chk("plot_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          pix_t e;
          e = sb.pop_front();
          chk("px_x", int'(vif.x), e.x);
          chk("px_y", int'(vif.y), e.y);
          chk("px_colour", int'(vif.colour), e.col);
          if (e.gap >= 0) chk("px_gap", cyc - last_plot - 1, e.gap);
        end
        last_plot = cyc;
        plot_cnt++;
      end
    end
  end

  initial begin
    int d0, p0;
    // Reset held with every mole requested: nothing may move.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rst_plot", int'(vif.plot), 0);
      chk("rst_busy", int'(vif.busy), 0);
      chk("rst_done", int'(vif.done), 0);
      chk("rst_colour", int'(vif.colour), 0);
    end
    push_block(0, 4, -1);
    push_block(1, 4, 2);
    push_block(2, 4, 2);
    d0 = done_cnt;
    resetn = 1'b1;
    wait_idle("all_on_drain");
    chk("all_on_done_cnt", done_cnt - d0, 3);

    push_block(0, 0, -1);
    push_block(1, 0, 2);
    push_block(2, 0, 2);
    mole_state = 3'b000;
    wait_idle("all_off_drain");

    // Single draw and first-plot latency.
    push_block(1, 4, -1);
    d0 = done_cnt;
    mole_state = 3'b010;
    chk("lat_before", int'(vif.plot), 0);
    @(posedge clock);
    #1 chk("lat_first_plot", int'(vif.plot), 1);
    wait_idle("single_drain");
    chk("single_done_cnt", done_cnt - d0, 1);
    chk("single_busy_idle", int'(vif.busy), 0);

    // last_grant=1 with blocks 0 and 2 pending: 2 must win.
    push_block(2, 4, -1);
    push_block(0, 4, 2);
    mole_state = 3'b111;
    wait_idle("fair_drain");

    push_block(0, 0, -1);
    mole_state = 3'b110;
    wait_idle("prep_game_off");

    // Game off erases drawn blocks 1 then 2; later input changes are ignored.
    push_block(1, 0, -1);
    push_block(2, 0, 2);
    game = 1'b0;
    wait_idle("game_off_drain");
    mole_state = 3'b001;
    repeat (20) @(negedge clock);
    mole_state = 3'b111;
    repeat (20) @(negedge clock);
    chk("game_off_busy", int'(vif.busy), 0);
    mole_state = 3'b000;
    game = 1'b1;
    repeat (4) @(negedge clock);

    // Target drops mid-draw: block completes ON, then is redrawn OFF.
    push_block(0, 4, -1);
    push_block(0, 0, 2);
    p0 = plot_cnt;
    mole_state = 3'b001;
    wait_plots(p0 + 10, "mid_wait");
    @(negedge clock);
    mole_state = 3'b000;
    wait_idle("mid_drain");

    // Async reset at pixel 30 of block 2 while block 1 is on screen.
    push_block(1, 4, -1);
    mole_state = 3'b010;
    wait_idle("pre_rst_drain");
    push_block(2, 4, -1);
    p0 = plot_cnt;
    mole_state = 3'b110;
    wait_plots(p0 + 30, "rst_wait");
    #2 resetn = 1'b0;
    #1;
    chk("async_plot", int'(vif.plot), 0);
    chk("async_busy", int'(vif.busy), 0);
    chk("async_colour", int'(vif.colour), 0);
    sb.delete();
    mole_state = 3'b000;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (100) @(negedge clock);
    chk("post_rst_quiet", int'(vif.busy), 0);
    push_block(1, 4, -1);
    mole_state = 3'b010;
    wait_idle("post_rst_redraw");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
